// File: rtl/defines_pkg.sv
// Shared types, default sizes and the forwarding-priority helper for the SPU result pipes.
// Entry fields are sized by the *_D constants; instance parameters must match them.
package defines_pkg;

  localparam int unsigned NUM_LANES_D   = 2;
  localparam int unsigned DEPTH_D       = 7;
  localparam int unsigned DATA_WD_D     = 128;
  localparam int unsigned ADDR_WD_D     = 7;
  localparam int unsigned LAT_WD_D      = 3;
  localparam int unsigned NUM_SRC_D     = 3;
  localparam int unsigned FLUSH_DEPTH_D = 2;

  typedef struct packed {
    logic                 v;
    logic [ADDR_WD_D-1:0] addr;
    logic [LAT_WD_D-1:0]  lat;
    logic                 rdy;
    logic [DATA_WD_D-1:0] data;
  } entry_t;

  typedef struct packed {
    logic                 hit;
    logic                 rdy;
    logic [DATA_WD_D-1:0] data;
  } fw_sel_t;

  // Candidates are offered lowest priority first; a later match replaces the earlier pick.
  function automatic fw_sel_t fw_prio(fw_sel_t best, entry_t e, logic [ADDR_WD_D-1:0] addr);
    fw_sel_t sel;
    sel = best;
    if (e.v && (e.addr == addr)) begin
      sel.hit  = 1'b1;
      sel.rdy  = e.rdy;
      sel.data = e.data;
    end
    return sel;
  endfunction

endpackage

// File: rtl/spu_result_pipes_if.sv
// Issue, result, operand-forwarding and writeback signals of the SPU result pipes.
interface spu_result_pipes_if
  import defines_pkg::*;
#(
  parameter int unsigned NUM_LANES = NUM_LANES_D,
  parameter int unsigned DATA_WD   = DATA_WD_D,
  parameter int unsigned ADDR_WD   = ADDR_WD_D,
  parameter int unsigned LAT_WD    = LAT_WD_D,
  parameter int unsigned NUM_SRC   = NUM_SRC_D
) ();

  logic [NUM_LANES-1:0]                 iss_valid;
  logic [NUM_LANES*ADDR_WD-1:0]         iss_rt_addr;
  logic [NUM_LANES*LAT_WD-1:0]          iss_lat;
  logic [NUM_LANES-1:0]                 res_valid;
  logic [NUM_LANES*DATA_WD-1:0]         res_data;
  logic [NUM_LANES*NUM_SRC*ADDR_WD-1:0] src_addr;
  logic [NUM_LANES*NUM_SRC*DATA_WD-1:0] src_rf_data;
  logic [NUM_LANES*NUM_SRC*DATA_WD-1:0] src_fw_data;
  logic [NUM_LANES-1:0]                 hazard;
  logic                                 flush;
  logic [NUM_LANES-1:0]                 wb_en;
  logic [NUM_LANES*ADDR_WD-1:0]         wb_addr;
  logic [NUM_LANES*DATA_WD-1:0]         wb_data;
  logic                                 err;

  modport master (
    output iss_valid, iss_rt_addr, iss_lat, res_valid, res_data, src_addr, src_rf_data, flush,
    input  src_fw_data, hazard, wb_en, wb_addr, wb_data, err
  );

  modport slave (
    input  iss_valid, iss_rt_addr, iss_lat, res_valid, res_data, src_addr, src_rf_data, flush,
    output src_fw_data, hazard, wb_en, wb_addr, wb_data, err
  );

endinterface

// File: rtl/result_lane.sv
// One issue lane's result pipe: a DEPTH-entry shift register with result capture and
// per-cycle protocol-error detection.
module result_lane
  import defines_pkg::*;
#(
  parameter int unsigned DEPTH       = DEPTH_D,
  parameter int unsigned DATA_WD     = DATA_WD_D,
  parameter int unsigned ADDR_WD     = ADDR_WD_D,
  parameter int unsigned LAT_WD      = LAT_WD_D,
  parameter int unsigned FLUSH_DEPTH = FLUSH_DEPTH_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               iss_valid_i,
  input  logic [ADDR_WD-1:0] iss_addr_i,
  input  logic [LAT_WD-1:0]  iss_lat_i,
  input  logic               res_valid_i,
  input  logic [DATA_WD-1:0] res_data_i,
  output entry_t [DEPTH:1]   pipe_o,
  output logic               err_o
);

  entry_t [DEPTH:1] pipe_q, pipe_d;
  logic lat_ok, res_hit, res_miss, killed, at_res;

  always_comb begin
    pipe_d   = '0;
    res_hit  = 1'b0;
    res_miss = 1'b0;
    killed   = 1'b0;
    at_res   = 1'b0;
    lat_ok   = (iss_lat_i != '0) && (int'(iss_lat_i) < int'(DEPTH));
    if (iss_valid_i && lat_ok && !flush_i) begin
      pipe_d[1].v    = 1'b1;
      pipe_d[1].addr = iss_addr_i;
      pipe_d[1].lat  = iss_lat_i;
    end
    for (int k = 1; k < int'(DEPTH); k++) begin
      killed = flush_i && (k <= int'(FLUSH_DEPTH));
      at_res = pipe_q[k].v && (int'(pipe_q[k].lat) == k);
      // A result aimed at a killed entry is consumed silently.
      if (at_res && res_valid_i) res_hit = 1'b1;
      if (at_res && !res_valid_i && !killed) res_miss = 1'b1;
      if (!killed) begin
        pipe_d[k+1] = pipe_q[k];
        if (at_res) begin
          pipe_d[k+1].rdy  = 1'b1;
          pipe_d[k+1].data = res_valid_i ? res_data_i : '0;
        end
      end
    end
    err_o = (iss_valid_i && !lat_ok) || res_miss || (res_valid_i && !res_hit);
  end

  always_ff @(posedge clk) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  assign pipe_o = pipe_q;

endmodule

// File: rtl/spu_result_pipes.sv
// SPU result pipes: per-lane result shift registers, cross-lane operand forwarding with
// hazard detection, register-file writeback and a sticky protocol-error flag.
module spu_result_pipes
  import defines_pkg::*;
#(
  parameter int unsigned NUM_LANES   = NUM_LANES_D,
  parameter int unsigned DEPTH       = DEPTH_D,
  parameter int unsigned DATA_WD     = DATA_WD_D,
  parameter int unsigned ADDR_WD     = ADDR_WD_D,
  parameter int unsigned LAT_WD      = LAT_WD_D,
  parameter int unsigned NUM_SRC     = NUM_SRC_D,
  parameter int unsigned FLUSH_DEPTH = FLUSH_DEPTH_D
) (
  input logic               clk,
  input logic               rst,
  spu_result_pipes_if.slave bus_if
);

  entry_t [DEPTH:1]     pipe [NUM_LANES];
  logic [NUM_LANES-1:0] lane_err;
  logic                 err_q;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    result_lane #(
      .DEPTH      (DEPTH),
      .DATA_WD    (DATA_WD),
      .ADDR_WD    (ADDR_WD),
      .LAT_WD     (LAT_WD),
      .FLUSH_DEPTH(FLUSH_DEPTH)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (bus_if.flush),
      .iss_valid_i(bus_if.iss_valid[l]),
      .iss_addr_i (bus_if.iss_rt_addr[l*ADDR_WD +: ADDR_WD]),
      .iss_lat_i  (bus_if.iss_lat[l*LAT_WD +: LAT_WD]),
      .res_valid_i(bus_if.res_valid[l]),
      .res_data_i (bus_if.res_data[l*DATA_WD +: DATA_WD]),
      .pipe_o     (pipe[l]),
      .err_o      (lane_err[l])
    );
  end

  always_comb begin
    bus_if.wb_en   = '0;
    bus_if.wb_addr = '0;
    bus_if.wb_data = '0;
    for (int l = 0; l < int'(NUM_LANES); l++) begin
      bus_if.wb_en[l]                        = pipe[l][DEPTH].v;
      bus_if.wb_addr[l*ADDR_WD +: ADDR_WD]   = pipe[l][DEPTH].addr;
      bus_if.wb_data[l*DATA_WD +: DATA_WD]   = pipe[l][DEPTH].data;
    end
  end

  // Walk stages oldest-first and lanes low-to-high so the last match wins.
  always_comb begin
    fw_sel_t sel;
    sel                = '0;
    bus_if.src_fw_data = bus_if.src_rf_data;
    bus_if.hazard      = '0;
    for (int l = 0; l < int'(NUM_LANES); l++) begin
      for (int s = 0; s < int'(NUM_SRC); s++) begin
        sel = '0;
        for (int st = int'(DEPTH); st >= 2; st--) begin
          for (int ln = 0; ln < int'(NUM_LANES); ln++) begin
            sel = fw_prio(sel, pipe[ln][st],
                          bus_if.src_addr[(l*NUM_SRC+s)*ADDR_WD +: ADDR_WD]);
          end
        end
        if (sel.hit) begin
          bus_if.src_fw_data[(l*NUM_SRC+s)*DATA_WD +: DATA_WD] = sel.data;
          if (!sel.rdy) bus_if.hazard[l] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            err_q <= 1'b0;
    else if (|lane_err) err_q <= 1'b1;
  end

  assign bus_if.err = err_q;

endmodule

// File: doc/spu_result_pipes.md
SPU_RESULT_PIPES -- requirements
Module: spu_result_pipes

Interface
REQ-001 SHALL have parameter NUM_LANES, default 2: number of issue lanes (lane 0 even, lane 1 odd).
REQ-002 SHALL have parameter DEPTH, default 7: result-pipe stages per lane, numbered 1..DEPTH.
REQ-003 SHALL have parameter DATA_WD, default 128: register data width.
REQ-004 SHALL have parameter ADDR_WD, default 7: register address width.
REQ-005 SHALL have parameter LAT_WD, default 3: latency field width; must satisfy 2^LAT_WD >= DEPTH.
REQ-006 SHALL have parameter NUM_SRC, default 3: source operands per lane (RA, RB, RC).
REQ-007 SHALL have parameter FLUSH_DEPTH, default 2: stages 1..FLUSH_DEPTH are killed by flush.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-009 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have port iss_valid, input, NUM_LANES bits: issue strobe, one per lane.
REQ-011 SHALL have port iss_rt_addr, input, NUM_LANES*ADDR_WD bits: destination register of each issued instruction.
REQ-012 SHALL have port iss_lat, input, NUM_LANES*LAT_WD bits: result stage L of each issued instruction.
REQ-013 SHALL have port res_valid, input, NUM_LANES bits: the execution unit presents a result.
REQ-014 SHALL have port res_data, input, NUM_LANES*DATA_WD bits: the presented result value.
REQ-015 SHALL have port src_addr, input, NUM_LANES*NUM_SRC*ADDR_WD bits: operand addresses.
REQ-016 SHALL have port src_rf_data, input, NUM_LANES*NUM_SRC*DATA_WD bits: register-file read data.
REQ-017 SHALL have port src_fw_data, output, NUM_LANES*NUM_SRC*DATA_WD bits: forwarded operand data.
REQ-018 SHALL have port hazard, output, NUM_LANES bits: a lane operand matches an in-flight result that is not yet ready.
REQ-019 SHALL have port flush, input, 1 bit: branch-mispredict kill.
REQ-020 SHALL have ports wb_en (NUM_LANES bits), wb_addr (NUM_LANES*ADDR_WD bits) and wb_data (NUM_LANES*DATA_WD bits), all outputs: register-file write port.
REQ-021 SHALL have port err, output, 1 bit: sticky protocol-error flag.

Function
REQ-022 SHALL hold per lane per stage an entry {v, addr, lat, rdy, data}; every cycle entries shift from stage k to stage k+1 with no stall.
REQ-023 SHALL load an iss_valid with 1 <= iss_lat <= DEPTH-1 into stage 1 with v=1, rdy=0; a lane without issue loads v=0.
REQ-024 SHALL drop an issue with iss_lat = 0 or iss_lat >= DEPTH (no entry loaded) and set err.
REQ-025 SHALL, when a lane's valid entry is in stage L = lat with res_valid high, capture res_data into that entry so it arrives in stage L+1 with rdy=1.
REQ-026 SHALL set err on res_valid with no valid entry at its result stage, or on a valid entry at its result stage with res_valid low; in the latter case the entry moves on with rdy=1 and data=0.
REQ-027 SHALL drive, combinationally, wb_en = stage-DEPTH v, with wb_addr and wb_data taken from that entry, per lane.
REQ-028 SHALL forward each operand from the matching (v && addr == src_addr) entry across all lanes and stages 2..DEPTH; priority is lowest stage number first, then highest lane index; with no match, src_rf_data passes through.
REQ-029 SHALL assert hazard[l] when the highest-priority match for any lane-l operand has rdy=0; src_fw_data for that operand is then don't-care.
REQ-030 SHALL, on flush, clear v of every lane's entry in stages 1..FLUSH_DEPTH at the clock edge (including an entry being issued that cycle); older stages continue and write back normally.
REQ-031 SHALL give the stage shift priority over res capture: flush on the cycle an entry is captured in a killed stage discards the capture and raises no err.
REQ-032 SHALL let two lanes write the same address in one cycle: both wb_en assert; forwarding still applies the lane-index priority.

Reset
REQ-033 SHALL, on rst, clear all v, rdy and err and zero all data; wb_en=0, hazard=0 and src_fw_data=src_rf_data from the next cycle onward.
REQ-034 SHALL, on rst mid-operation, discard all in-flight entries without writeback, with rst taking priority over iss_valid and flush.

Structure
REQ-035 SHALL place the entry struct type, default parameter constants and the forwarding-priority function in defines_pkg.
REQ-036 SHALL instantiate one sub-module, result_lane, per lane (NUM_LANES copies) holding that lane's DEPTH-entry shift register and err sources; the top holds the forwarding mux and err OR.

Verification
REQ-037 SHALL check: lane0 issue addr 5, lat 2, res 0xA5.. at stage 2 -> wb_en[0]=1, wb_addr 5, data 0xA5.. exactly DEPTH-1 cycles after the issue edge.
REQ-038 SHALL check: lane1 operand addr 5 while the entry is in stage 2 before capture -> hazard[1]=1; one cycle later -> hazard=0 and src_fw_data=0xA5...
REQ-039 SHALL check: both lanes in flight to addr 9 (lane0 stage 4, lane1 stage 3) -> lane1 data forwarded; with both in stage 4, lane1 data is still forwarded.
REQ-040 SHALL check: flush with entries in stages 1, 2 and 3 -> entries in stages 1 and 2 never write back, the stage-3 entry writes back, err=0.
REQ-041 SHALL check: iss_lat=0 -> err=1 and no writeback; res_valid with an empty pipe -> err=1; rst -> err=0 and all wb_en=0.
REQ-042 SHALL run a randomized issue/flush stream against a reference register-file model, checking that every forwarded value equals the model's value.
